ram_bist_ctrl: RTL and testbench

Built-in self-test sequencer that sits directly upstream of the single-port synchronous RAM and drives its address, write-data, chip-select, write-enable and read-enable inputs. On `start` it runs two write-then-read-back passes over every address and checks the RAM's registered `data_out` against an address-derived pattern. It reports pass/fail, the first failing location and an error count. The RAM is used unchanged; this block replaces hand-written fill/readback stimulus in system bring-up.

---
 rtl/ram_bist_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// =============================================================================
// ram_bist_ctrl : two-pass write/read-back BIST sequencer for a sync RAM  (rev 1.0)
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_bist_ctrl #(
  parameter int ADD_SIZE    = 10,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADD_SIZE+1:0]   err_count,
  output logic [ADD_SIZE-1:0]   fail_addr,
  output logic [WORD_SIZE-1:0]  fail_data,
  output logic                  fail_pass,
  output logic [ADD_SIZE-1:0]   ram_addr,
  output logic [WORD_SIZE-1:0]  ram_data_in,
  input  logic [WORD_SIZE-1:0]  ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_cs,
  output logic                  ram_read_enable
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADD_SIZE-1:0] c_LAST    = ADD_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADD_SIZE+1:0] c_ERR_MAX = '1;

  state_t                 r_state;
  logic [ADD_SIZE-1:0]    r_addr;
  logic                   r_pidx;
  logic                   r_cs;
  logic                   r_we;
  logic                   r_re;
  logic [WORD_SIZE-1:0]   r_din;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [ADD_SIZE+1:0]    r_err;
  logic [ADD_SIZE-1:0]    r_faddr;
  logic [WORD_SIZE-1:0]   r_fdata;
  logic                   r_fpass;
  logic                   r_have_fail;
  logic                   r_cmp_vld;
  logic [ADD_SIZE-1:0]    r_cmp_addr;
  logic [WORD_SIZE-1:0]   r_cmp_exp;

  logic [ADD_SIZE-1:0]    w_addr_inc;
  logic                   w_mismatch;
  logic [ADD_SIZE+1:0]    w_err_nxt;

  // Pass 0 writes 2*a (truncated to the word), pass 1 writes its inverse.
  function automatic logic [WORD_SIZE-1:0] f_pattern(input logic [ADD_SIZE-1:0] a,
                                                     input logic k);
    logic [WORD_SIZE-1:0] p;
    p = WORD_SIZE'({a, 1'b0});
    return k ? ~p : p;
  endfunction

  assign w_addr_inc = r_addr + ADD_SIZE'(1);
  assign w_mismatch = r_cmp_vld && (ram_data_out != r_cmp_exp);
  assign w_err_nxt  = (w_mismatch && (r_err != c_ERR_MAX)) ? r_err + (ADD_SIZE+2)'(1) : r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_pidx      <= 1'b0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_din       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_faddr     <= '0;
      r_fdata     <= '0;
      r_fpass     <= 1'b0;
      r_have_fail <= 1'b0;
      r_cmp_vld   <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
    end else begin
      // Read data registered by the RAM at the end of an RD cycle is checked one cycle later.
      r_cmp_vld  <= (r_state == S_RD);
      r_cmp_addr <= r_addr;
      r_cmp_exp  <= f_pattern(r_addr, r_pidx);
      r_err      <= w_err_nxt;
      if (w_mismatch && !r_have_fail) begin
        r_have_fail <= 1'b1;
        r_faddr     <= r_cmp_addr;
        r_fdata     <= ram_data_out;
        r_fpass     <= r_pidx;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_WR;
            r_addr      <= '0;
            r_pidx      <= 1'b0;
            r_cs        <= 1'b1;
            r_we        <= 1'b1;
            r_re        <= 1'b0;
            r_din       <= f_pattern('0, 1'b0);
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_faddr     <= '0;
            r_fdata     <= '0;
            r_fpass     <= 1'b0;
            r_have_fail <= 1'b0;
          end
        end
        S_WR: begin
          if (r_addr == c_LAST) begin
            r_state <= S_RD;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b1;
            r_din   <= '0;
          end else begin
            r_addr <= w_addr_inc;
            r_din  <= f_pattern(w_addr_inc, r_pidx);
          end
        end
        S_RD: begin
          if (r_addr == c_LAST) begin
            r_state <= S_DRAIN;
            r_addr  <= '0;
            r_cs    <= 1'b0;
            r_re    <= 1'b0;
          end else begin
            r_addr <= w_addr_inc;
          end
        end
        S_DRAIN: begin
          if (!r_pidx) begin
            r_state <= S_WR;
            r_pidx  <= 1'b1;
            r_addr  <= '0;
            r_cs    <= 1'b1;
            r_we    <= 1'b1;
            r_din   <= f_pattern('0, 1'b1);
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign fail_addr        = r_faddr;
  assign fail_data        = r_fdata;
  assign fail_pass        = r_fpass;
  assign ram_addr         = r_addr;
  assign ram_data_in      = r_din;
  assign ram_write_enable = r_we;
  assign ram_cs           = r_cs;
  assign ram_read_enable  = r_re;

endmodule

`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
// =============================================================================
// tb_ram_bist_ctrl : bench with behavioural RAM, fault injection and reference model  (rev 1.0)
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_bist_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int M  = 1024;
  localparam int M2 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;

  logic          w_busy, w_done, w_pass, w_fpass, w_we, w_cs, w_re;
  logic [AW+1:0] w_err;
  logic [AW-1:0] w_faddr, w_addr;
  logic [DW-1:0] w_fdata, w_din;
  logic [DW-1:0] r_dout;

  logic          w2_busy, w2_done, w2_pass, w2_fpass, w2_we, w2_cs, w2_re;
  logic [AW+1:0] w2_err;
  logic [AW-1:0] w2_faddr, w2_addr;
  logic [DW-1:0] w2_fdata, w2_din;
  logic [DW-1:0] r2_dout;

  ram_bist_ctrl #(.ADD_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(M)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(w_busy), .done(w_done), .pass(w_pass),
    .err_count(w_err), .fail_addr(w_faddr), .fail_data(w_fdata), .fail_pass(w_fpass),
    .ram_addr(w_addr), .ram_data_in(w_din), .ram_data_out(r_dout),
    .ram_write_enable(w_we), .ram_cs(w_cs), .ram_read_enable(w_re)
  );

  ram_bist_ctrl #(.ADD_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(M2)) u_dut_small (
    .clk(clk), .rst(rst), .start(start2), .busy(w2_busy), .done(w2_done), .pass(w2_pass),
    .err_count(w2_err), .fail_addr(w2_faddr), .fail_data(w2_fdata), .fail_pass(w2_fpass),
    .ram_addr(w2_addr), .ram_data_in(w2_din), .ram_data_out(r2_dout),
    .ram_write_enable(w2_we), .ram_cs(w2_cs), .ram_read_enable(w2_re)
  );

  // Behavioural RAMs; the large one ORs a per-(pass,address) fault mask into its read data.
  logic [DW-1:0] mem  [M];
  logic [DW-1:0] mem2 [M];
  logic [DW-1:0] f_mask [2][M];
  int rd_total = 0;
  int rd_base  = 0;

  always @(posedge clk) begin
    if (w_cs && w_we) mem[w_addr] <= w_din;
    if (w_cs && w_re) begin
      r_dout   <= mem[w_addr] | f_mask[((rd_total - rd_base) >= M) ? 1 : 0][w_addr];
      rd_total <= rd_total + 1;
    end
    if (w2_cs && w2_we) mem2[w2_addr] <= w2_din;
    if (w2_cs && w2_re) r2_dout <= mem2[w2_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] wr5 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs1();
    return {9'd0, w_busy, w_done, w_pass, w_err, w_faddr, w_fdata, w_fpass,
            w_addr, w_din, w_we, w_cs, w_re};
  endfunction

  function automatic logic [63:0] outs2();
    return {9'd0, w2_busy, w2_done, w2_pass, w2_err, w2_faddr, w2_fdata, w2_fpass,
            w2_addr, w2_din, w2_we, w2_cs, w2_re};
  endfunction

  task automatic clear_faults();
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < M; a++) f_mask[p][a] = '0;
  endtask

  // Reference: walk both passes in order, compare pattern against what the faulty RAM returns.
  task automatic ref_model(output int e_err, output int e_addr, output int e_data, output int e_pass);
    logic [DW-1:0] pat, obs;
    e_err = 0; e_addr = 0; e_data = 0; e_pass = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < M; a++) begin
        pat = DW'((2 * a) % 256);
        if (p == 1) pat = ~pat;
        obs = pat | f_mask[p][a];
        if (obs != pat) begin
          if (e_err == 0) begin
            e_addr = a; e_data = int'(obs); e_pass = p;
          end
          e_err++;
        end
      end
    end
    if (e_err > 4095) e_err = 4095;
  endtask

  // Start a run; optional stray start pulse and mid-run reset. Returns the done cycle (-1 timeout, -2 reset).
  task automatic run(input string tag, input int pulse_at, input int rst_at, output int done_cyc);
    rd_base = rd_total;
    wr5.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_c0"}, {63'd0, w_busy}, 64'd1);
    done_cyc = -1;
    for (int c = 0; c < 5000; c++) begin
      if (w_done) begin
        done_cyc = c;
        break;
      end
      if (w_we && w_addr == 10'd5) wr5.push_back(w_din);
      start = (c == pulse_at);
      if (c == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk({tag, ".rst_outs"}, outs1(), 64'd0);
        done_cyc = -2;
        return;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, ".busy_done"}, {63'd0, w_busy}, 64'd0);
  endtask

  task automatic check_vs_model(input string tag, input int done_cyc);
    int e_err, e_addr, e_data, e_pass;
    ref_model(e_err, e_addr, e_data, e_pass);
    chk({tag, ".done_cyc"}, 64'(done_cyc), 64'(4 * M + 2));
    chk({tag, ".err"},      64'(w_err),    64'(e_err));
    chk({tag, ".pass"},     64'(w_pass),   64'(e_err == 0));
    chk({tag, ".faddr"},    64'(w_faddr),  64'(e_addr));
    chk({tag, ".fdata"},    64'(w_fdata),  64'(e_data));
    chk({tag, ".fpass"},    64'(w_fpass),  64'(e_pass));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d, nf, maxa;
    logic [DW-1:0] w9 [$];
    rst = 1'b1; start = 1'b1; start2 = 1'b1;
    clear_faults();
    repeat (3) tick();
    chk("reset.outs",  outs1(), 64'd0);
    chk("reset.outs2", outs2(), 64'd0);
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    tick();
    chk("idle.busy", {63'd0, w_busy}, 64'd0);

    // Healthy RAM.
    run("healthy", -1, -1, d);
    chk("healthy.done_cyc", 64'(d), 64'd4098);
    chk("healthy.pass", {63'd0, w_pass}, 64'd1);
    chk("healthy.err", 64'(w_err), 64'd0);
    chk("healthy.wr5_n", 64'(wr5.size()), 64'd2);
    if (wr5.size() == 2) begin
      chk("healthy.wr5_p0", 64'(wr5[0]), 64'd10);
      chk("healthy.wr5_p1", 64'(wr5[1]), 64'd245);
    end

    // Bit 0 stuck high on addr 3 readback in pass 0 only.
    clear_faults();
    f_mask[0][3] = 8'h01;
    run("fault3", -1, -1, d);
    chk("fault3.done_cyc", 64'(d), 64'd4098);
    chk("fault3.faddr", 64'(w_faddr), 64'd3);
    chk("fault3.fdata", 64'(w_fdata), 64'd7);
    chk("fault3.fpass", 64'(w_fpass), 64'd0);
    chk("fault3.err",   64'(w_err),   64'd1);
    chk("fault3.pass",  64'(w_pass),  64'd0);

    // Same bit forced in pass 1 is harmless (249 already has bit 0 set).
    clear_faults();
    f_mask[1][3] = 8'h01;
    run("fault3p1", -1, -1, d);
    chk("fault3p1.err",  64'(w_err),  64'd0);
    chk("fault3p1.pass", 64'(w_pass), 64'd1);

    // Two faults; the pass-0 one must be reported first.
    clear_faults();
    f_mask[1][100] = 8'h80;
    f_mask[0][7]   = 8'h01;
    run("multi", -1, -1, d);
    chk("multi.err",   64'(w_err),   64'd2);
    chk("multi.faddr", 64'(w_faddr), 64'd7);
    chk("multi.fpass", 64'(w_fpass), 64'd0);
    chk("multi.fdata", 64'(w_fdata), 64'd15);

    // Control: stray start, mid-run reset, clean restart.
    clear_faults();
    run("ignore_start", 500, -1, d);
    chk("ignore_start.done_cyc", 64'(d), 64'd4098);
    chk("ignore_start.pass", {63'd0, w_pass}, 64'd1);
    run("midrst", -1, 1500, d);
    chk("midrst.code", 64'(d), -64'sd2);
    run("restart", -1, -1, d);
    chk("restart.done_cyc", 64'(d), 64'd4098);
    chk("restart.pass", {63'd0, w_pass}, 64'd1);

    // Randomised fault sets against the reference model.
    for (int it = 0; it < 3; it++) begin
      clear_faults();
      nf = $urandom_range(1, 6);
      for (int k = 0; k < nf; k++)
        f_mask[$urandom_range(0, 1)][$urandom_range(0, M - 1)] |= DW'($urandom_range(1, 255));
      run($sformatf("rand%0d", it), -1, -1, d);
      check_vs_model($sformatf("rand%0d", it), d);
    end

    // Small memory instance.
    w9.delete();
    maxa = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    d = -1;
    for (int c = 0; c < 200; c++) begin
      if (w2_done) begin
        d = c;
        break;
      end
      if (int'(w2_addr) > maxa) maxa = int'(w2_addr);
      if (w2_we && w2_addr == 10'd9) w9.push_back(w2_din);
      tick();
    end
    chk("small.done_cyc", 64'(d), 64'd42);
    chk("small.maxaddr", 64'(maxa), 64'd9);
    chk("small.pass", {63'd0, w2_pass}, 64'd1);
    chk("small.wr9_n", 64'(w9.size()), 64'd2);
    if (w9.size() == 2) begin
      chk("small.wr9_p0", 64'(w9[0]), 64'd18);
      chk("small.wr9_p1", 64'(w9[1]), 64'd237);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
